lif_neuron_array: RTL and testbench

//   N parallel leaky integrate-and-fire neurons sharing one threshold and one input strobe.

---
 rtl/lif_neuron_array.sv | 143 ++++++++++++++
 tb/tb_lif_neuron_array.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   N parallel leaky integrate-and-fire neurons sharing one threshold and one
//   input strobe. Each neuron integrates its own W-bit current slice with a
//   programmable right-shift leak and saturating addition. A neuron fires
//   (registered one-cycle spike) when the saturated sum reaches the threshold,
//   then resets to zero and sits out REFRAC further updates.
//
//   Optional feature macro: LIF_SPIKE_COUNT_EN
//     defined   -> spike_total_o counts spikes (saturating at 16'hFFFF)
//     undefined -> spike_total_o is tied to zero, no counter logic
//
// Ports
//   clk            in   1     clock, rising edge
//   rst_n          in   1     synchronous reset, active-low
//   en_i           in   1     global enable; low freezes state, counters, spike regs
//   cur_valid_i    in   1     current bus valid; update this cycle when en_i is high
//   current_i      in   N*W   neuron i current at [i*W +: W], unsigned
//   threshold_i    in   W     firing threshold, sampled on each update
//   spike_o        out  N     registered spike pulses, bit i = neuron i
//   state_o        out  N*W   membrane potentials, neuron i at [i*W +: W]
//   refrac_busy_o  out  N     bit i high while neuron i is refractory
//   spike_total_o  out  16    total spike count (see macro above)
//
// While en_i is low the spike register holds its value rather than clearing,
// so a pulse that lands just before a freeze is still seen by the counter
// once the block is re-enabled. With en_i high and no strobe, spikes clear.
module lif_neuron_array #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             cur_valid_i,
    input  logic [N*W-1:0]   current_i,
    input  logic [W-1:0]     threshold_i,
    output logic [N-1:0]     spike_o,
    output logic [N*W-1:0]   state_o,
    output logic [N-1:0]     refrac_busy_o,
    output logic [15:0]      spike_total_o
);

    localparam logic [3:0] REFRAC_L = 4'(REFRAC);

    logic [W-1:0] state_q [N];
    logic [W-1:0] state_d [N];
    logic [3:0]   rcnt_q  [N];
    logic [3:0]   rcnt_d  [N];
    logic [N-1:0] spike_q;
    logic [N-1:0] spike_d;

    logic [W:0]   sum_w [N];
    logic [W-1:0] nxt_w [N];

    logic upd;
    assign upd = en_i & cur_valid_i;

    for (genvar g = 0; g < N; g++) begin : g_neuron
        // Sum is one bit wider than the operands so overflow is visible
        // and can be clamped instead of wrapping.
        assign sum_w[g] = {1'b0, current_i[g*W +: W]} + ({1'b0, state_q[g]} >> LEAK_SHIFT);
        assign nxt_w[g] = sum_w[g][W] ? {W{1'b1}} : sum_w[g][W-1:0];

        assign state_o[g*W +: W] = state_q[g];
        assign refrac_busy_o[g]  = (rcnt_q[g] != 4'd0);
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
        end
        spike_d = en_i ? '0 : spike_q;

        if (upd) begin
            for (int i = 0; i < N; i++) begin
                if (rcnt_q[i] != 4'd0) begin
                    state_d[i] = '0;
                    rcnt_d[i]  = rcnt_q[i] - 4'd1;
                end else if (nxt_w[i] >= threshold_i) begin
                    spike_d[i] = 1'b1;
                    state_d[i] = '0;
                    rcnt_d[i]  = REFRAC_L;
                end else begin
                    state_d[i] = nxt_w[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= '0;
                rcnt_q[i]  <= '0;
            end
            spike_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] total_q;
    logic [15:0] total_d;
    logic [16:0] total_sum;
    logic [3:0]  pop;

    // Counts the registered spike vector, so the total lags the pulse by one cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + 4'(spike_q[i]);
        end
        total_sum = {1'b0, total_q} + 17'(pop);
        total_d   = total_q;
        if (en_i) begin
            total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign spike_total_o = total_q;
`else
    assign spike_total_o = 16'h0000;
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
module tb_lif_neuron_array;

    localparam int N = 4;
    localparam int W = 8;
    localparam int LS = 1;
    localparam int RF = 2;

    logic            clk;
    logic            rst_n;
    logic            en_i;
    logic            cur_valid_i;
    logic [N*W-1:0]  current_i;
    logic [W-1:0]    threshold_i;
    logic [N-1:0]    spike_o;
    logic [N*W-1:0]  state_o;
    logic [N-1:0]    refrac_busy_o;
    logic [15:0]     spike_total_o;

    lif_neuron_array #(.N(N), .W(W), .LEAK_SHIFT(LS), .REFRAC(RF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en_i),
        .cur_valid_i   (cur_valid_i),
        .current_i     (current_i),
        .threshold_i   (threshold_i),
        .spike_o       (spike_o),
        .state_o       (state_o),
        .refrac_busy_o (refrac_busy_o),
        .spike_total_o (spike_total_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: plain integers per neuron.
    int m_st  [N];
    int m_rc  [N];
    int m_sp  [N];
    int m_tot;

`ifdef LIF_SPIKE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v,
                              input logic [31:0] cur, input int thr);
        int pc;
        int c;
        int n;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_rc[i] = 0; m_sp[i] = 0;
            end
            m_tot = 0;
            return;
        end
        if (!e) return;
        if (CNT_EN) begin
            pc = 0;
            for (int i = 0; i < N; i++) pc += m_sp[i];
            m_tot = (m_tot + pc > 65535) ? 65535 : m_tot + pc;
        end
        for (int i = 0; i < N; i++) begin
            m_sp[i] = 0;
            if (v) begin
                if (m_rc[i] > 0) begin
                    m_st[i] = 0;
                    m_rc[i] = m_rc[i] - 1;
                end else begin
                    c = int'((cur >> (8 * i)) & 32'hFF);
                    n = c + m_st[i] / (1 << LS);
                    if (n > 255) n = 255;
                    if (n >= thr) begin
                        m_sp[i] = 1; m_st[i] = 0; m_rc[i] = RF;
                    end else begin
                        m_st[i] = n;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] m_state_bus();
        logic [31:0] b = '0;
        for (int i = 0; i < N; i++) b[i*8 +: 8] = 8'(m_st[i]);
        return b;
    endfunction

    function automatic logic [3:0] m_spike_bus();
        logic [3:0] b = '0;
        for (int i = 0; i < N; i++) b[i] = (m_sp[i] != 0);
        return b;
    endfunction

    function automatic logic [3:0] m_busy_bus();
        logic [3:0] b = '0;
        for (int i = 0; i < N; i++) b[i] = (m_rc[i] != 0);
        return b;
    endfunction

    task automatic do_cycle(input bit r, input bit e, input bit v,
                            input logic [31:0] cur, input logic [7:0] thr);
        rst_n = r; en_i = e; cur_valid_i = v; current_i = cur; threshold_i = thr;
        @(posedge clk);
        model_step(r, e, v, cur, int'(thr));
        #1;
        check("state", state_o, m_state_bus());
        check("spike", 32'(spike_o), 32'(m_spike_bus()));
        check("busy", 32'(refrac_busy_o), 32'(m_busy_bus()));
        check("total", 32'(spike_total_o), 32'(m_tot));
    endtask

    typedef struct {
        bit          r;
        logic [31:0] cur;
        logic [7:0]  thr;
        logic [31:0] exp_state;
        logic [3:0]  exp_spike;
        logic [3:0]  exp_busy;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // reset with full current and strobe high
        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000};
        // neuron 0 integrates 0x20, neuron 1 integrates 0x50 and fires, thr 0x7F
        vecs[2]  = '{1'b1, 32'h0000_5020, 8'h7F, 32'h0000_5020, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b1, 32'h0000_5020, 8'h7F, 32'h0000_7830, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b1, 32'h0000_5020, 8'h7F, 32'h0000_0038, 4'b0010, 4'b0010};
        vecs[5]  = '{1'b1, 32'h0000_5020, 8'h7F, 32'h0000_003C, 4'b0000, 4'b0010};
        vecs[6]  = '{1'b1, 32'h0000_5020, 8'h7F, 32'h0000_003E, 4'b0000, 4'b0000};
        vecs[7]  = '{1'b1, 32'h0000_5020, 8'h7F, 32'h0000_503F, 4'b0000, 4'b0000};
        vecs[8]  = '{1'b1, 32'h0000_5020, 8'h7F, 32'h0000_783F, 4'b0000, 4'b0000};
        // saturation on neuron 2 with thr 0xFF
        vecs[9]  = '{1'b0, 32'h0000_0000, 8'hFF, 32'h0000_0000, 4'b0000, 4'b0000};
        vecs[10] = '{1'b1, 32'h00F0_0000, 8'hFF, 32'h00F0_0000, 4'b0000, 4'b0000};
        vecs[11] = '{1'b1, 32'h00F0_0000, 8'hFF, 32'h0000_0000, 4'b0100, 4'b0100};
        // thr 0: every non-refractory neuron fires even with zero current
        vecs[12] = '{1'b1, 32'h0000_0000, 8'h00, 32'h0000_0000, 4'b1011, 4'b1111};

        rst_n = 1'b0; en_i = 1'b0; cur_valid_i = 1'b0; current_i = '0; threshold_i = '0;
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_rc[i] = 0; m_sp[i] = 0;
        end
        m_tot = 0;
        @(negedge clk);

        for (int k = 0; k < 13; k++) begin
            do_cycle(vecs[k].r, 1'b1, 1'b1, vecs[k].cur, vecs[k].thr);
            check($sformatf("vec%0d_state", k), state_o, vecs[k].exp_state);
            check($sformatf("vec%0d_spike", k), 32'(spike_o), 32'(vecs[k].exp_spike));
            check($sformatf("vec%0d_busy", k), 32'(refrac_busy_o), 32'(vecs[k].exp_busy));
        end
        // neuron 2 leaves refractory after two updates, then state stays 0 with no current
        do_cycle(1'b1, 1'b1, 1'b1, 32'h0, 8'hFF);
        check("sat_busy_after2", 32'(refrac_busy_o[2]), 32'h0);

        // Gating: strobe every other cycle, then freeze mid-refractory
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 8'h7F);
        for (int k = 0; k < 8; k++) begin
            do_cycle(1'b1, 1'b1, (k % 2) == 0, 32'h0000_5000, 8'h7F);
            if (k == 4) check("gate_spike_k4", 32'(spike_o), 32'h2);
            if (k == 5) check("gate_spike_k5", 32'(spike_o), 32'h0);
        end
        for (int k = 0; k < 5; k++) do_cycle(1'b1, 1'b0, 1'b1, 32'h0000_5000, 8'h7F);
        check("gate_frozen_busy", 32'(refrac_busy_o), 32'h2);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_5000, 8'h7F);
        check("gate_busy_clear", 32'(refrac_busy_o), 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_5000, 8'h7F);
        check("gate_resume", state_o, 32'h0000_5000);

        // Counter: thr 0, all currents 1, 6 updates
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 8'h00);
        for (int k = 0; k < 6; k++) do_cycle(1'b1, 1'b1, 1'b1, 32'h0101_0101, 8'h00);
        check("count_6upd", 32'(spike_total_o), CNT_EN ? 32'd8 : 32'd0);

`ifdef LIF_SPIKE_COUNT_EN
        for (int k = 0; k < 60000 && m_tot < 16'hFFF0; k++)
            do_cycle(1'b1, 1'b1, 1'b1, 32'h0101_0101, 8'h00);
        for (int k = 0; k < 200 && m_tot < 16'hFFFE; k++)
            do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0001, 8'h01);
        check("count_fffe", 32'(spike_total_o), 32'h0000_FFFE);
        for (int k = 0; k < 9; k++) do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0001, 8'h01);
        check("count_sat", 32'(spike_total_o), 32'h0000_FFFF);
`endif

        // Randomised run against the model
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 8'h00);
        for (int k = 0; k < 400; k++) begin
            do_cycle($urandom_range(0, 49) != 0,
                     $urandom_range(0, 9) != 0,
                     1'($urandom_range(0, 1)),
                     $urandom,
                     8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
